// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: owner encoding and strobe constants.
// Imported by the arbiter top.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DM   = 2'b10
  } own_e;

  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// IF/MEM arbiter for the single-ported unified memory.
// Define MEM_ARB_RR_EN for round-robin tie-break (default: DM wins ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  own_e own_q;
  own_e own_d;
  own_e gnt;
  own_e tie_win;
  logic if_elig;
  logic dm_elig;
  logic tie;

  // The requester in its response cycle sits out this cycle.
  assign if_elig = if_req && (own_q != OWN_IF) && !rst;
  assign dm_elig = dm_req && (own_q != OWN_DM) && !rst;
  assign tie     = if_elig && dm_elig;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  assign tie_win = last_q ? OWN_IF : OWN_DM;

  always_comb begin
    last_d = last_q;
    if (gnt == OWN_DM) begin
      last_d = 1'b1;
    end else if (gnt == OWN_IF) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign tie_win = OWN_DM;
`endif

  always_comb begin
    if (tie) begin
      gnt = tie_win;
    end else if (dm_elig) begin
      gnt = OWN_DM;
    end else if (if_elig) begin
      gnt = OWN_IF;
    end else begin
      gnt = OWN_NONE;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = WE_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt)
      OWN_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      OWN_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  assign own_d = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  assign if_valid = (own_q == OWN_IF) && !rst;
  assign dm_valid = (own_q == OWN_DM) && !rst;
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;
  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_conflict_cnt (
    .clk(clk),
    .rst(rst),
    .inc(tie),
    .cnt(conflict_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model and a reference memory.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          dm_req;
  logic [3:0]    dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          dm_stall;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .if_stall(if_stall),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_valid(dm_valid),
    .dm_stall(dm_stall),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  function automatic logic [31:0] word_init(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h11223344;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0]  we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // memory instance: registered read, byte-strobed write
  logic        mem_init;
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= word_init(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[9:2]];
      mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_we);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // reference model: 0 none, 1 IF, 2 DM
  typedef struct {
    int          who;
    logic [31:0] data;
    bit          st;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] ref_mem [0:255];
  int          m_own;
  int          m_last;
  int          m_cnt;
  bit          x_if_v;
  bit          x_dm_v;
  logic [31:0] o_if_rdata;
  logic [31:0] o_dm_rdata;

  task automatic step();
    bit          eif, edm, vi, vd, sd;
    int          g, tw;
    logic [31:0] ea, ew, di, dd, w;
    logic [3:0]  ewe;
    pend_t       p;
    @(negedge clk);
    vi = 0; vd = 0; sd = 0; di = '0; dd = '0;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      if (p.who == 1) begin
        vi = 1; di = p.data;
      end else begin
        vd = 1; dd = p.data; sd = p.st;
      end
    end
    if (rst) begin
      vi = 0; vd = 0;
    end
    eif = if_req && (m_own != 1) && !rst;
    edm = dm_req && (m_own != 2) && !rst;
`ifdef MEM_ARB_RR_EN
    tw = (m_last == 2) ? 1 : 2;
`else
    tw = 2;
`endif
    if (eif && edm) g = tw;
    else if (edm)   g = 2;
    else if (eif)   g = 1;
    else            g = 0;
    ea  = (g == 1) ? if_addr : (g == 2) ? dm_addr : 32'h0;
    ewe = (g == 2) ? dm_we : 4'h0;
    ew  = (g == 2) ? dm_wdata : 32'h0;
    chk("mem_en",    32'(mem_en),    32'(g != 0));
    chk("mem_addr",  mem_addr,       ea);
    chk("mem_we",    32'(mem_we),    32'(ewe));
    chk("mem_wdata", mem_wdata,      ew);
    chk("if_valid",  32'(if_valid),  32'(vi));
    chk("dm_valid",  32'(dm_valid),  32'(vd));
    chk("if_rdata",  if_rdata,       vi ? di : 32'h0);
    if (!(vd && sd)) chk("dm_rdata", dm_rdata, vd ? dd : 32'h0);
    chk("if_stall",  32'(if_stall),  32'(if_req && !vi));
    chk("dm_stall",  32'(dm_stall),  32'(dm_req && !vd));
    chk("cnt",       32'(conflict_cnt), 32'(m_cnt));
    x_if_v = vi;
    x_dm_v = vd;
    o_if_rdata = if_rdata;
    o_dm_rdata = dm_rdata;
    if (rst) begin
      m_own = 0; m_cnt = 0; m_last = 1;
    end else begin
      if (eif && edm && m_cnt < CMAX) m_cnt++;
      m_own = g;
      if (g != 0) begin
        m_last = g;
        w = ref_mem[ea[9:2]];
        pq.push_back('{g, w, (g == 2) && (ewe != 4'h0)});
        ref_mem[ea[9:2]] = merge(w, ew, ewe);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dm_txn(input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d);
    bit done;
    done = 0;
    dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d;
    for (int k = 0; k < 6 && !done; k++) begin
      step();
      done = x_dm_v;
    end
    chk("dm_done", 32'(done), 32'd1);
    dm_req = 0; dm_we = 4'h0;
  endtask

  initial begin
    bit done;
    for (int i = 0; i < 256; i++) ref_mem[i] = word_init(i);
    m_own = 0; m_cnt = 0; m_last = 1;
    mem_init = 1; rst = 1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
    step();
    mem_init = 0;
    step();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);

    // fetch only
    rst = 0; if_req = 1; if_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (x_if_v) begin
        chk("fetch_word", o_if_rdata, word_init(int'(if_addr >> 2)));
        if_addr += 4;
      end
      chk("fetch_pat", 32'(if_valid), 32'(i % 2 == 0));
      chk("fetch_dmv", 32'(dm_valid), 32'd0);
    end
    if_req = 0;
    step(); step();

    // collision at reset exit
    rst = 1; if_req = 1; if_addr = 32'h8;
    dm_req = 1; dm_we = 4'h0; dm_addr = 32'h100;
    step();
    rst = 0;
    step();
    chk("coll_dmv", 32'(dm_valid), 32'd1);
    chk("coll_cnt", 32'(conflict_cnt), 32'd1);
    step();
    chk("coll_dmdata", o_dm_rdata, word_init(64));
    dm_req = 0;
    chk("coll_ifv", 32'(if_valid), 32'd1);
    step();
    if_req = 0;
    step();

    // store then load, then byte store
    dm_txn(4'hF, 32'h40, 32'hDEADBEEF);
    dm_txn(4'h0, 32'h40, 32'h0);
    chk("ld_deadbeef", o_dm_rdata, 32'hDEADBEEF);
    dm_txn(4'b0010, 32'h0, 32'h0000AB00);
    dm_txn(4'h0, 32'h0, 32'h0);
    chk("byte_merge", o_dm_rdata, 32'h1122AB44);
    step();

    // reset in the response cycle of a fetch
    if_req = 1; if_addr = 32'h8;
    step();
    rst = 1;
    #1;
    chk("rstmid_ifv", 32'(if_valid), 32'd0);
    chk("rstmid_men", 32'(mem_en), 32'd0);
    step();
    rst = 0;
    chk("rstmid_cnt", 32'(conflict_cnt), 32'd0);
    done = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      step();
      done = x_if_v;
    end
    chk("rstmid_refetch", 32'(done), 32'd1);
    if_req = 0;
    step();

    // saturation: repeated ties from an idle owner
    for (int i = 0; i < 10; i++) begin
      if_req = 1; if_addr = 32'h10;
      dm_req = 1; dm_we = 4'h0; dm_addr = 32'h20;
      for (int k = 0; k < 3; k++) begin
        step();
        if (x_if_v) if_req = 0;
        if (x_dm_v) dm_req = 0;
      end
    end
    chk("sat_cnt", 32'(conflict_cnt), 32'(CMAX));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      step();
      if (x_if_v || !if_req) begin
        if_req  = ($urandom_range(0, 9) < 7);
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (x_dm_v || !dm_req) begin
        dm_req   = ($urandom_range(0, 9) < 6);
        dm_addr  = 32'($urandom_range(0, 255)) << 2;
        dm_wdata = $urandom;
        case ($urandom_range(0, 3))
          0, 1:    dm_we = 4'h0;
          2:       dm_we = 4'hF;
          default: dm_we = 4'($urandom_range(1, 15));
        endcase
      end
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
